// File: rtl/decoder38_seq_pkg.sv
// decoder38_seq_pkg
// Shared definitions for the sequenced 3-to-8 decoder:
//   state_t      - FSM state encoding (S_IDLE / S_DRIVE / S_GAP)
//   LINE_IDLE    - all-high output pattern (no line selected)
//   CODE_W       - width of an encoded request
//   FIFO_DEPTH   - request buffer depth
//   code_to_line - active-low code to active-low one-hot line pattern
package decoder38_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] LINE_IDLE  = 8'hFF;
  localparam int         CODE_W     = 3;
  localparam int         FIFO_DEPTH = 2;

  // The code arrives in the encoder's active-low form, so line n = ~code.
  // The result has exactly one low bit.
  function automatic logic [7:0] code_to_line(input logic [CODE_W-1:0] code);
    logic [7:0]        line;
    logic [CODE_W-1:0] idx;
    idx       = ~code;
    line      = LINE_IDLE;
    line[idx] = 1'b0;
    return line;
  endfunction

endpackage

// File: rtl/decoder38_seq_fifo2_code.sv
// fifo2_code
// Two-entry, 3-bit synchronous FIFO holding pending decoder requests.
// Ports:
//   clk       in   clock
//   flush     in   synchronous clear of all entries (reset or blanking)
//   push      in   write push_data (ignored when full)
//   push_data in   code to store
//   pop       in   drop the head entry (ignored when empty)
//   pop_data  out  head entry, valid while empty = 0
//   full      out  both entries occupied
//   empty     out  no entries occupied
module fifo2_code
  import decoder38_seq_pkg::*;
(
  input  logic              clk,
  input  logic              flush,
  input  logic              push,
  input  logic [CODE_W-1:0] push_data,
  input  logic              pop,
  output logic [CODE_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  logic [CODE_W-1:0] mem_reg [FIFO_DEPTH];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;
  logic              push_en;
  logic              pop_en;

  assign full     = (count_reg == 2'd2);
  assign empty    = (count_reg == 2'd0);
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  assign pop_data = mem_reg[rd_ptr_reg];

  // Storage needs no clearing: an entry is only read after it was written.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!flush && push_en && (wr_ptr_reg == 1'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop_en) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + 2'(push_en) - 2'(pop_en);
    end
  end

endmodule

// File: rtl/decoder38_seq.sv
// decoder38_seq
// Sequenced 3-to-8 decoder. Active-low codes are accepted over a
// ready/valid handshake into a 2-entry FIFO; each one drives its
// active-low line for HOLD cycles, with one all-high gap cycle between
// consecutive lines.
// Parameters:
//   HOLD    cycles each line is held low (1..255)
//   HOLD_W  hold counter width
// Ports:
//   iClk    in   clock
//   iRst    in   synchronous active-high reset
//   iEI     in   active-low enable; 1 blanks outputs and flushes requests
//   iData   in   active-low code (111 -> line 0, 000 -> line 7)
//   iValid  in   request strobe
//   oReady  out  combinational: FIFO not full and iEI = 0
//   oData   out  registered active-low one-hot line, 8'hFF when idle
//   oDone   out  registered one-cycle pulse after a line is released
//   oBusy   out  registered; FSM active or requests pending
module decoder38_seq
  import decoder38_seq_pkg::*;
#(
  parameter int HOLD   = 4,
  parameter int HOLD_W = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEI,
  input  logic [CODE_W-1:0] iData,
  input  logic              iValid,
  output logic              oReady,
  output logic [7:0]        oData,
  output logic              oDone,
  output logic              oBusy
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);

  state_t            state_reg, state_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [7:0]        line_reg, line_next;
  logic              done_reg, done_next;
  logic              busy_reg, busy_next;

  logic              fifo_push;
  logic              fifo_pop;
  logic [CODE_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;

  // Readiness uses occupancy before any same-cycle pop.
  assign oReady    = !fifo_full && !iEI;
  assign fifo_push = iValid && oReady;

  fifo2_code u_fifo (
    .clk       (iClk),
    .flush     (iRst | iEI),
    .push      (fifo_push),
    .push_data (iData),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    line_next  = line_reg;
    done_next  = 1'b0;
    busy_next  = 1'b0;
    fifo_pop   = 1'b0;

    case (state_reg)
      S_IDLE, S_GAP: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          hold_next  = HOLD_LOAD;
          line_next  = code_to_line(fifo_head);
          state_next = S_DRIVE;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_DRIVE: begin
        if (hold_reg != '0) begin
          hold_next = hold_reg - HOLD_W'(1);
        end else begin
          // Release first; the gap state gives break-before-make.
          line_next  = LINE_IDLE;
          done_next  = 1'b1;
          state_next = fifo_empty ? S_IDLE : S_GAP;
        end
      end
      default: begin
        line_next  = LINE_IDLE;
        state_next = S_IDLE;
      end
    endcase

    // Busy reflects work known before this edge; a code pushed on the
    // same edge becomes visible one edge later.
    busy_next = (state_next != S_IDLE) || !fifo_empty;

    if (iEI) begin
      fifo_pop   = 1'b0;
      state_next = S_IDLE;
      line_next  = LINE_IDLE;
      done_next  = 1'b0;
      busy_next  = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_reg <= S_IDLE;
      hold_reg  <= '0;
      line_reg  <= LINE_IDLE;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      line_reg  <= line_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
    end
  end

  assign oData = line_reg;
  assign oDone = done_reg;
  assign oBusy = busy_reg;

endmodule

// File: tb/tb_decoder38_seq.sv
// tb_decoder38_seq
// Directed bench for decoder38_seq: one HOLD=4 instance and one HOLD=1
// instance sharing clock, reset and enable.
module tb_decoder38_seq;

  logic       clk;
  logic       rst;
  logic       ei;
  logic [2:0] data;
  logic       valid;
  logic       ready;
  logic [7:0] odata;
  logic       done;
  logic       busy;

  logic [2:0] data1;
  logic       valid1;
  logic       ready1;
  logic [7:0] odata1;
  logic       done1;
  logic       busy1;

  int checks = 0;
  int errors = 0;

  decoder38_seq #(.HOLD(4), .HOLD_W(8)) dut (
    .iClk   (clk),
    .iRst   (rst),
    .iEI    (ei),
    .iData  (data),
    .iValid (valid),
    .oReady (ready),
    .oData  (odata),
    .oDone  (done),
    .oBusy  (busy)
  );

  decoder38_seq #(.HOLD(1), .HOLD_W(8)) dut1 (
    .iClk   (clk),
    .iRst   (rst),
    .iEI    (ei),
    .iData  (data1),
    .iValid (valid1),
    .oReady (ready1),
    .oData  (odata1),
    .oDone  (done1),
    .oBusy  (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected oData after edge a+j of the back-to-back run (111, 000, 101).
  function automatic logic [7:0] exp_b2b(input int j);
    if (j <= 4)       return 8'hFE;
    else if (j == 5)  return 8'hFF;
    else if (j <= 9)  return 8'h7F;
    else if (j == 10) return 8'hFF;
    else if (j <= 14) return 8'hFB;
    else              return 8'hFF;
  endfunction

  initial begin
    rst = 1'b1; ei = 1'b0; data = 3'b000; valid = 1'b0;
    data1 = 3'b000; valid1 = 1'b0;
    tick();
    tick();
    check("rst_data", odata, 8'hFF);
    check("rst_done", {7'd0, done}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_data_h1", odata1, 8'hFF);
    rst = 1'b0;
    tick();
    check("idle_ready", {7'd0, ready}, 8'd1);

    // Single request 110 -> line 1 (8'hFD) for 4 cycles.
    $display("single: push code 110");
    data = 3'b110; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("single_data_%0d", i), odata, 8'hFD);
      check($sformatf("single_done_%0d", i), {7'd0, done}, 8'd0);
      if (i == 1) check("single_busy_on", {7'd0, busy}, 8'd1);
    end
    tick();
    check("single_release", odata, 8'hFF);
    check("single_done", {7'd0, done}, 8'd1);
    check("single_busy_off", {7'd0, busy}, 8'd0);
    tick();
    check("single_done_clear", {7'd0, done}, 8'd0);

    // Back-to-back 111, 000, 101; a push offered while full (with a pop on
    // the same edge) must be rejected and never appear on the outputs.
    $display("b2b: push codes 111 000 101");
    data = 3'b111; valid = 1'b1;
    tick();
    data = 3'b000;
    tick();
    check("b2b_data_1", odata, exp_b2b(1));
    data = 3'b101;
    tick();
    check("b2b_data_2", odata, exp_b2b(2));
    check("b2b_full_ready_2", {7'd0, ready}, 8'd0);
    valid = 1'b0;
    for (int j = 3; j <= 16; j++) begin
      tick();
      check($sformatf("b2b_data_%0d", j), odata, exp_b2b(j));
      check($sformatf("b2b_done_%0d", j), {7'd0, done},
            (j == 5 || j == 10 || j == 15) ? 8'd1 : 8'd0);
      if (j == 3 || j == 4) check($sformatf("b2b_full_ready_%0d", j), {7'd0, ready}, 8'd0);
      if (j == 5) begin
        $display("b2b: offer code 010 while full");
        data = 3'b010; valid = 1'b1;
        #1;
        check("full_pop_ready", {7'd0, ready}, 8'd0);
      end
      if (j == 6) valid = 1'b0;
    end
    check("b2b_busy_end", {7'd0, busy}, 8'd0);
    tick();
    check("b2b_no_extra", odata, 8'hFF);

    // Enable pulsed mid-line with one entry queued.
    $display("ei: push codes 111 000, then pulse iEI");
    data = 3'b111; valid = 1'b1;
    tick();
    data = 3'b000;
    tick();
    check("ei_drive_1", odata, 8'hFE);
    valid = 1'b0;
    tick();
    check("ei_drive_2", odata, 8'hFE);
    ei = 1'b1;
    tick();
    check("ei_blank_data", odata, 8'hFF);
    check("ei_blank_done", {7'd0, done}, 8'd0);
    check("ei_blank_busy", {7'd0, busy}, 8'd0);
    check("ei_blank_ready", {7'd0, ready}, 8'd0);
    ei = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("ei_after_data_%0d", i), odata, 8'hFF);
      check($sformatf("ei_after_busy_%0d", i), {7'd0, busy}, 8'd0);
    end
    check("ei_after_ready", {7'd0, ready}, 8'd1);

    // Reset during GAP with a request offered on the reset edge.
    $display("rst: push codes 111 000, reset in gap with code 011 offered");
    data = 3'b111; valid = 1'b1;
    tick();
    data = 3'b000;
    tick();
    valid = 1'b0;
    for (int i = 2; i <= 4; i++) tick();
    check("gap_pre_drive", odata, 8'hFE);
    tick();
    check("gap_release", odata, 8'hFF);
    check("gap_done", {7'd0, done}, 8'd1);
    rst = 1'b1; valid = 1'b1; data = 3'b011;
    tick();
    check("gap_rst_data", odata, 8'hFF);
    check("gap_rst_done", {7'd0, done}, 8'd0);
    check("gap_rst_busy", {7'd0, busy}, 8'd0);
    rst = 1'b0; valid = 1'b0;
    tick();
    check("gap_rst_nocap_1", odata, 8'hFF);
    check("gap_rst_nocap_busy", {7'd0, busy}, 8'd0);
    tick();
    check("gap_rst_nocap_2", odata, 8'hFF);

    // HOLD = 1 instance: alternating single-cycle low/high.
    $display("hold1: push codes 111 000 101");
    data1 = 3'b111; valid1 = 1'b1;
    tick();
    data1 = 3'b000;
    tick();
    check("h1_data_1", odata1, 8'hFE);
    check("h1_done_1", {7'd0, done1}, 8'd0);
    data1 = 3'b101;
    tick();
    check("h1_data_2", odata1, 8'hFF);
    check("h1_done_2", {7'd0, done1}, 8'd1);
    valid1 = 1'b0;
    tick();
    check("h1_data_3", odata1, 8'h7F);
    check("h1_done_3", {7'd0, done1}, 8'd0);
    tick();
    check("h1_data_4", odata1, 8'hFF);
    check("h1_done_4", {7'd0, done1}, 8'd1);
    tick();
    check("h1_data_5", odata1, 8'hFB);
    tick();
    check("h1_data_6", odata1, 8'hFF);
    check("h1_done_6", {7'd0, done1}, 8'd1);
    tick();
    check("h1_data_7", odata1, 8'hFF);
    check("h1_done_7", {7'd0, done1}, 8'd0);
    check("h1_busy_7", {7'd0, busy1}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
